// File: rtl/axi4_bram_slave.sv
// AXI4 slave over a single-port 32-bit BRAM, one read or write burst at a time (INCR/FIXED, up to 256 beats).
// Latency: R beat 0 one cycle after AR, then 1 beat/cycle; B one cycle after last W. R/B held until ready.
module axi4_bram_slave #(
  parameter int MEM_BYTES = 65536,
  parameter int ID_W      = 4,
  parameter int ADDR_W    = 31
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              bram_axi4_aw_valid,
  output logic              bram_axi4_aw_ready,
  input  logic [ID_W-1:0]   bram_axi4_aw_id,
  input  logic [ADDR_W-1:0] bram_axi4_aw_addr,
  input  logic [7:0]        bram_axi4_aw_len,
  input  logic [2:0]        bram_axi4_aw_size,
  input  logic [1:0]        bram_axi4_aw_burst,
  input  logic              bram_axi4_w_valid,
  output logic              bram_axi4_w_ready,
  input  logic [31:0]       bram_axi4_w_data,
  input  logic [3:0]        bram_axi4_w_strb,
  input  logic              bram_axi4_w_last,
  output logic              bram_axi4_b_valid,
  input  logic              bram_axi4_b_ready,
  output logic [ID_W-1:0]   bram_axi4_b_id,
  output logic [1:0]        bram_axi4_b_resp,
  input  logic              bram_axi4_ar_valid,
  output logic              bram_axi4_ar_ready,
  input  logic [ID_W-1:0]   bram_axi4_ar_id,
  input  logic [ADDR_W-1:0] bram_axi4_ar_addr,
  input  logic [7:0]        bram_axi4_ar_len,
  input  logic [2:0]        bram_axi4_ar_size,
  input  logic [1:0]        bram_axi4_ar_burst,
  output logic              bram_axi4_r_valid,
  input  logic              bram_axi4_r_ready,
  output logic [ID_W-1:0]   bram_axi4_r_id,
  output logic [31:0]       bram_axi4_r_data,
  output logic [1:0]        bram_axi4_r_resp,
  output logic              bram_axi4_r_last
);

  localparam int AB    = $clog2(MEM_BYTES);
  localparam int WORDS = MEM_BYTES / 4;

  typedef enum logic [1:0] {IDLE, WRITE, WRESP, READ} state_e;

  state_e            state_q, state_d;
  logic              prio_w_q, prio_w_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic [AB-1:0]     addr_q, addr_d;
  logic [7:0]        len_q, len_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [2:0]        size_q, size_d;
  logic [1:0]        burst_q, burst_d;
  logic              err_q, err_d;

  logic [31:0]       mem [WORDS];
  logic [31:0]       rdata_q;

  logic              ram_en;
  logic              ram_we;
  logic [AB-3:0]     ram_idx;
  logic [3:0]        ram_be;

  logic              aw_hs;
  logic              ar_hs;
  logic              w_hs;
  logic              last_beat;
  logic [AB-1:0]     addr_nxt;
  logic              unused_addr_bits;

  // Upper address bits only select this slave in the interconnect; here they alias.
  assign unused_addr_bits = ^{bram_axi4_aw_addr[ADDR_W-1:AB], bram_axi4_ar_addr[ADDR_W-1:AB]};

  function automatic logic [AB-1:0] next_addr(input logic [AB-1:0] a,
                                              input logic [2:0]    sz,
                                              input logic [1:0]    bt);
    logic [AB-1:0] step;
    step = (sz > 3'd2) ? AB'(4) : (AB'(1) << sz);
    next_addr = (bt == 2'b00) ? a : a + step;
  endfunction

  assign bram_axi4_aw_ready = (state_q == IDLE) && bram_axi4_aw_valid &&
                              (!bram_axi4_ar_valid || prio_w_q);
  assign bram_axi4_ar_ready = (state_q == IDLE) && bram_axi4_ar_valid &&
                              (!bram_axi4_aw_valid || !prio_w_q);
  assign bram_axi4_w_ready  = (state_q == WRITE);
  assign bram_axi4_b_valid  = (state_q == WRESP);
  assign bram_axi4_r_valid  = (state_q == READ);

  assign aw_hs     = bram_axi4_aw_valid && bram_axi4_aw_ready;
  assign ar_hs     = bram_axi4_ar_valid && bram_axi4_ar_ready;
  assign w_hs      = bram_axi4_w_valid && bram_axi4_w_ready;
  assign last_beat = (cnt_q == len_q);
  assign addr_nxt  = next_addr(addr_q, size_q, burst_q);

  assign bram_axi4_b_id   = id_q;
  assign bram_axi4_b_resp = {err_q, 1'b0};
  assign bram_axi4_r_id   = id_q;
  assign bram_axi4_r_data = rdata_q;
  assign bram_axi4_r_resp = 2'b00;
  assign bram_axi4_r_last = (state_q == READ) && last_beat;

  always_comb begin
    state_d  = state_q;
    prio_w_d = prio_w_q;
    id_d     = id_q;
    addr_d   = addr_q;
    len_d    = len_q;
    cnt_d    = cnt_q;
    size_d   = size_q;
    burst_d  = burst_q;
    err_d    = err_q;
    ram_en   = 1'b0;
    ram_we   = 1'b0;
    ram_be   = 4'h0;
    ram_idx  = addr_q[AB-1:2];

    case (state_q)
      IDLE: begin
        if (aw_hs) begin
          id_d     = bram_axi4_aw_id;
          addr_d   = bram_axi4_aw_addr[AB-1:0];
          len_d    = bram_axi4_aw_len;
          size_d   = bram_axi4_aw_size;
          burst_d  = bram_axi4_aw_burst;
          cnt_d    = 8'd0;
          prio_w_d = 1'b0;
          state_d  = WRITE;
        end else if (ar_hs) begin
          id_d     = bram_axi4_ar_id;
          addr_d   = bram_axi4_ar_addr[AB-1:0];
          len_d    = bram_axi4_ar_len;
          size_d   = bram_axi4_ar_size;
          burst_d  = bram_axi4_ar_burst;
          cnt_d    = 8'd0;
          prio_w_d = 1'b1;
          ram_en   = 1'b1;
          ram_idx  = bram_axi4_ar_addr[AB-1:2];
          state_d  = READ;
        end
      end
      WRITE: begin
        if (w_hs) begin
          ram_en = 1'b1;
          ram_we = 1'b1;
          ram_be = bram_axi4_w_strb;
          addr_d = addr_nxt;
          cnt_d  = cnt_q + 8'd1;
          if (bram_axi4_w_last != last_beat) begin
            err_d = 1'b1;
          end
          if (last_beat) begin
            state_d = WRESP;
          end
        end
      end
      WRESP: begin
        if (bram_axi4_b_ready) begin
          err_d   = 1'b0;
          state_d = IDLE;
        end
      end
      READ: begin
        // The next word is fetched on the same edge the current beat is consumed.
        if (bram_axi4_r_ready) begin
          if (last_beat) begin
            state_d = IDLE;
          end else begin
            addr_d  = addr_nxt;
            cnt_d   = cnt_q + 8'd1;
            ram_en  = 1'b1;
            ram_idx = addr_nxt[AB-1:2];
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q  <= IDLE;
      prio_w_q <= 1'b0;
      id_q     <= '0;
      addr_q   <= '0;
      len_q    <= 8'd0;
      cnt_q    <= 8'd0;
      size_q   <= 3'd0;
      burst_q  <= 2'b00;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      prio_w_q <= prio_w_d;
      id_q     <= id_d;
      addr_q   <= addr_d;
      len_q    <= len_d;
      cnt_q    <= cnt_d;
      size_q   <= size_d;
      burst_q  <= burst_d;
      err_q    <= err_d;
    end
  end

  // RAM contents and its output register survive reset.
  always_ff @(posedge clock) begin
    if (ram_en) begin
      if (ram_we) begin
        for (int b = 0; b < 4; b++) begin
          if (ram_be[b]) begin
            mem[ram_idx][8*b +: 8] <= bram_axi4_w_data[8*b +: 8];
          end
        end
      end else begin
        rdata_q <= mem[ram_idx];
      end
    end
  end

endmodule

// File: doc/axi4_bram_slave.md
# axi4_bram_slave

AXI4 slave wrapping a 64 KB single-port synchronous block RAM. It is mapped at 0x60010000–0x6001FFFF and attached to crossbar master port 1, the BRAM slot of the peripheral interconnect. It serves one transaction at a time, either read or write, with INCR and FIXED bursts up to 256 beats. After the first beat it sustains one beat per cycle.

## Interface
Parameters:
- MEM_BYTES, 65536: RAM size in bytes; power of two.
- ID_W, 4: AXI ID width.
- ADDR_W, 31: AXI address width.

Ports:
- clock  in  1  sole clock; all logic is rising-edge.
- resetn  in  1  asynchronous, active-low reset.
- bram_axi4_aw_valid / aw_ready  in / out  1 / 1  AW handshake.
- bram_axi4_aw_id, aw_addr, aw_len, aw_size, aw_burst  in  ID_W, ADDR_W, 8, 3, 2  write address channel.
- bram_axi4_w_valid / w_ready  in / out  1 / 1  W handshake.
- bram_axi4_w_data, w_strb, w_last  in  32, 4, 1  write data, byte enables, last-beat flag.
- bram_axi4_b_valid / b_ready  out / in  1 / 1  B handshake.
- bram_axi4_b_id, b_resp  out  ID_W, 2  write response.
- bram_axi4_ar_valid / ar_ready  in / out  1 / 1  AR handshake.
- bram_axi4_ar_id, ar_addr, ar_len, ar_size, ar_burst  in  ID_W, ADDR_W, 8, 3, 2  read address channel.
- bram_axi4_r_valid / r_ready  out / in  1 / 1  R handshake.
- bram_axi4_r_id, r_data, r_resp, r_last  out  ID_W, 32, 2, 1  read data channel.

## Operation
- RAM is organised as MEM_BYTES/4 words of 32 bits, with per-byte write enables, one port, and registered read (1-cycle).
- Word index = addr[log2(MEM_BYTES)-1:2]. Upper address bits are ignored, so addresses alias modulo MEM_BYTES and bursts wrap from the top word to word 0.
- Burst address update:
  - FIXED: address does not change.
  - INCR: address += 1<<size, with size clamped to 2.
  - WRAP: treated as INCR.
  - Reserved burst type 3: treated as INCR.
- FSM states:
  - IDLE
  - WRITE: w_ready=1.
  - WRESP: b_valid=1.
  - READ: r_valid is driven by the pipeline.
- Arbitration in IDLE:
  - aw_ready = aw_valid && (!ar_valid || prio_w).
  - ar_ready = ar_valid && (!aw_valid || !prio_w).
  - Both readies are 0 outside IDLE.
  - prio_w clears when a write is accepted and sets when a read is accepted, so priority alternates.
- On AW accept, latch id, addr, len, size and burst into beat counter cnt=0, then go to WRITE.
- WRITE:
  - Each W handshake writes the bytes enabled by w_strb, then advances addr and cnt.
  - The beat with cnt==len goes to WRESP.
  - err is set if w_last differs from (cnt==len) on any beat.
- WRESP:
  - b_id is the latched id; b_resp = err ? 2'b10 (SLVERR) : 2'b00.
  - b_valid is held until b_ready, then the FSM goes to IDLE and err clears.
- On AR accept:
  - Latch the same fields as for AW.
  - The RAM read of ar_addr is issued in the same cycle.
  - Go to READ.
- READ:
  - r_data is the RAM output register; it is stable while no new read is issued.
  - r_id is the latched id; r_resp = 2'b00; r_last = (cnt==len).
  - On an R handshake with !r_last: advance addr and cnt and issue the next read in the same cycle.
  - On an R handshake with r_last: r_valid goes to 0 and the FSM goes to IDLE.
- Reset (async assert):
  - FSM goes to IDLE; prio_w=0; cnt=0; err=0.
  - Any in-flight transaction is dropped and no response is sent.
  - RAM contents are preserved; power-up contents are undefined.

## Timing
- Reset values: aw_ready=0, w_ready=0, b_valid=0, ar_ready=0, r_valid=0, r_last=0, b_resp=0, r_resp=0, b_id=0, r_id=0.
- aw_ready and ar_ready are combinational from the valids in IDLE.
- Write, AW handshake at cycle T: w_ready is 1 from T+1. A 1-beat write with w_valid held completes its W beat at T+1; b_valid=1 at T+2.
- Write throughput: 1 beat/cycle while w_valid=1.
- Read, AR handshake at cycle T: r_valid=1 with beat 0 at T+1. With r_ready held high, beat k appears at T+1+k.
- Read backpressure: r_ready=0 holds r_data, r_last and r_valid unchanged.
- Turnaround: the cycle after the final B or R handshake is IDLE, so the next address can be accepted in that cycle.
- AW and AR valid in the same cycle: exactly one ready is asserted. The loser stays pending; it wins the next IDLE cycle if its valid is still high.
- A W beat presented while in IDLE is not accepted.

## Test plan
- Single write then read: AW addr 0x60010010, len 0, W data 0xDEADBEEF, strb 0xF → b_resp 0. Then AR at the same address → r_data 0xDEADBEEF, r_last 1 at T+1.
- INCR burst: len 3 write to 0x60010100 with data 1..4, beat 2 strb 0x3 over prior data 0xFFFFFFFF → readback 1, 2, 0xFFFF0003, 4 on 4 consecutive cycles.
- FIXED burst, len 2, data A, B, C → one word holds C. Wrap: INCR len 1 from 0x6001FFFC writes word 0x3FFF, then word 0.
- Simultaneous AW and AR right after reset → read granted first, write next. A second simultaneous pair → read granted first again, because priority alternates.
- r_ready toggled 1-0-0-1 during a len 3 read → data is held stable during the stall cycles; 4 beats delivered with no loss or duplication.
- w_last asserted on beat 1 of a len 2 write → 3 beats accepted, then b_resp = 2'b10. Reset mid-burst → all valids/readies 0 immediately; the next transaction works normally.
